hazard_ctrl: RTL and testbench

Pipeline hazard and sequencing controller for the 5-stage RV32I core. It drives the enable and flush inputs of the PC, IF_ID, ID_EX and EX_MEM pipeline registers. It resolves load-use stalls, taken-branch flushes, multi-cycle data-memory waits (with timeout) and ecall/ebreak halts. It sits beside the ID stage and takes hazard information from IF_ID, ID_EX, EX and MEM.

---
 rtl/hazard_ctrl.sv | 163 ++++++++++++++++
 tb/tb_hazard_ctrl.sv | 139 +++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Hazard and sequencing controller for the 5-stage RV32I pipeline.
// Optional feature macro: HAZARD_PERF_EN builds the stall/flush event counters.
module hazard_ctrl #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic        id_uses_rs2,
    input  logic        ex_mem_rd,
    input  logic [4:0]  ex_rd,
    input  logic        branch_taken,
    input  logic        halt_req,
    input  logic        mem_busy,
    output logic        pc_enable,
    output logic        if_id_enable,
    output logic        if_id_flush,
    output logic        id_ex_enable,
    output logic        id_ex_flush,
    output logic        ex_mem_enable,
    output logic        halted,
    output logic        mem_timeout,
    output logic [31:0] stall_cnt,
    output logic [31:0] flush_cnt
);

    localparam int WCW = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [WCW-1:0] WAIT_LAST = WCW'(MEM_TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_RUN,
        ST_MEM_WAIT,
        ST_HALT
    } state_e;

    typedef struct packed {
        logic pc_en;
        logic if_id_en;
        logic if_id_fl;
        logic id_ex_en;
        logic id_ex_fl;
        logic ex_mem_en;
    } ctrl_t;

    localparam ctrl_t CTRL_OFF   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    localparam ctrl_t CTRL_PASS  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    localparam ctrl_t CTRL_FLUSH = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    // Load-use stall and HALT share one pattern: hold the front, bubble into EX, drain the back.
    localparam ctrl_t CTRL_HOLD  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

    state_e         state_q, state_d;
    logic [WCW-1:0] wait_cnt_q, wait_cnt_d;
    logic           halted_q, halted_d;
    logic           mem_timeout_q, mem_timeout_d;
    logic           load_use;
    ctrl_t          run_ctrl;
    ctrl_t          ctrl;

    assign load_use = ex_mem_rd && (ex_rd != 5'd0) &&
                      ((ex_rd == id_rs1) || (id_uses_rs2 && (ex_rd == id_rs2)));

    always_comb begin
        if (mem_busy)          run_ctrl = CTRL_OFF;
        else if (halt_req)     run_ctrl = CTRL_HOLD;
        else if (branch_taken) run_ctrl = CTRL_FLUSH;
        else if (load_use)     run_ctrl = CTRL_HOLD;
        else                   run_ctrl = CTRL_PASS;
    end

    always_comb begin
        // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latch).
        ctrl          = CTRL_OFF;
        state_d       = state_q;
        wait_cnt_d    = wait_cnt_q;
        mem_timeout_d = mem_timeout_q;
        if (!rst) begin
            unique case (state_q)
                ST_RUN: begin
                    ctrl = run_ctrl;
                    if (mem_busy) begin
                        state_d    = ST_MEM_WAIT;
                        wait_cnt_d = WCW'(1);
                    end else if (halt_req) begin
                        state_d = ST_HALT;
                    end
                end
                ST_MEM_WAIT: begin
                    ctrl = run_ctrl;
                    if (mem_busy) begin
                        if (wait_cnt_q == WAIT_LAST) begin
                            state_d       = ST_HALT;
                            mem_timeout_d = 1'b1;
                        end else begin
                            wait_cnt_d = wait_cnt_q + WCW'(1);
                        end
                    end else begin
                        state_d    = ST_RUN;
                        wait_cnt_d = '0;
                    end
                end
                ST_HALT: ctrl = CTRL_HOLD;
                default: state_d = ST_RUN;
            endcase
        end
        halted_d = (state_d == ST_HALT);
    end

    // NOTE: sequential state uses non-blocking assignments only; reset is synchronous.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_RUN;
            wait_cnt_q    <= '0;
            halted_q      <= 1'b0;
            mem_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            wait_cnt_q    <= wait_cnt_d;
            halted_q      <= halted_d;
            mem_timeout_q <= mem_timeout_d;
        end
    end

    assign pc_enable     = ctrl.pc_en;
    assign if_id_enable  = ctrl.if_id_en;
    assign if_id_flush   = ctrl.if_id_fl;
    assign id_ex_enable  = ctrl.id_ex_en;
    assign id_ex_flush   = ctrl.id_ex_fl;
    assign ex_mem_enable = ctrl.ex_mem_en;
    assign halted        = halted_q;
    assign mem_timeout   = mem_timeout_q;

`ifdef HAZARD_PERF_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] flush_cnt_q, flush_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (!ctrl.pc_en && (stall_cnt_q != 32'hFFFF_FFFF))
            stall_cnt_d = stall_cnt_q + 32'd1;
        if ((ctrl.if_id_fl || ctrl.id_ex_fl) && (flush_cnt_q != 32'hFFFF_FFFF))
            flush_cnt_d = flush_cnt_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl (MEM_TIMEOUT=4) with an expected-result queue.
module tb_hazard_ctrl;

    typedef struct packed {
        logic [5:0]  ctrl;   // {pc_en, if_id_en, if_id_fl, id_ex_en, id_ex_fl, ex_mem_en}
        logic        halted;
        logic        mem_timeout;
        logic [31:0] stall_cnt;
        logic [31:0] flush_cnt;
    } exp_t;

    localparam logic [5:0] C_OFF  = 6'b000000;
    localparam logic [5:0] C_RUN  = 6'b110101;
    localparam logic [5:0] C_BR   = 6'b111111;
    localparam logic [5:0] C_HOLD = 6'b000111;

`ifdef HAZARD_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  id_rs1, id_rs2, ex_rd;
    logic        id_uses_rs2, ex_mem_rd, branch_taken, halt_req, mem_busy;
    logic        pc_enable, if_id_enable, if_id_flush, id_ex_enable, id_ex_flush, ex_mem_enable;
    logic        halted, mem_timeout;
    logic [31:0] stall_cnt, flush_cnt;

    int          n_pass = 0;
    int          n_total = 0;
    logic [31:0] mdl_stall = '0;
    logic [31:0] mdl_flush = '0;
    exp_t        sb_q[$];

    always #5 clk = ~clk;

    hazard_ctrl #(.MEM_TIMEOUT(4)) dut (
        .clk(clk), .rst(rst),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs2(id_uses_rs2),
        .ex_mem_rd(ex_mem_rd), .ex_rd(ex_rd),
        .branch_taken(branch_taken), .halt_req(halt_req), .mem_busy(mem_busy),
        .pc_enable(pc_enable), .if_id_enable(if_id_enable), .if_id_flush(if_id_flush),
        .id_ex_enable(id_ex_enable), .id_ex_flush(id_ex_flush), .ex_mem_enable(ex_mem_enable),
        .halted(halted), .mem_timeout(mem_timeout),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // One clock cycle: drive inputs after the edge, push the expectation, compare at the falling edge.
    task automatic step(input string tag, input logic r,
                        input logic [4:0] rs1, input logic [4:0] rs2, input logic use2,
                        input logic ld, input logic [4:0] rd,
                        input logic br, input logic hr, input logic busy,
                        input logic [5:0] ctrl, input logic h, input logic mt);
        exp_t e, got;
        @(posedge clk);
        #1;
        rst = r; id_rs1 = rs1; id_rs2 = rs2; id_uses_rs2 = use2;
        ex_mem_rd = ld; ex_rd = rd; branch_taken = br; halt_req = hr; mem_busy = busy;
        e.ctrl        = ctrl;
        e.halted      = h;
        e.mem_timeout = mt;
        e.stall_cnt   = PERF ? mdl_stall : 32'd0;
        e.flush_cnt   = PERF ? mdl_flush : 32'd0;
        sb_q.push_back(e);
        if (r) begin
            mdl_stall = '0;
            mdl_flush = '0;
        end else begin
            if (!ctrl[5]) mdl_stall++;
            if (ctrl[3] || ctrl[1]) mdl_flush++;
        end
        @(negedge clk);
        n_total++;
        assert (sb_q.size() > 0) n_pass++;
        else begin
            $error("FAIL %s_queue: observed empty expected entry", tag);
            return;
        end
        got = sb_q.pop_front();
        check32({tag, "_ctrl"}, {26'd0, pc_enable, if_id_enable, if_id_flush,
                                 id_ex_enable, id_ex_flush, ex_mem_enable}, {26'd0, got.ctrl});
        check32({tag, "_halted"}, {31'd0, halted}, {31'd0, got.halted});
        check32({tag, "_mem_timeout"}, {31'd0, mem_timeout}, {31'd0, got.mem_timeout});
        check32({tag, "_stall_cnt"}, stall_cnt, got.stall_cnt);
        check32({tag, "_flush_cnt"}, flush_cnt, got.flush_cnt);
    endtask

    initial begin
        rst = 1'b1; id_rs1 = '0; id_rs2 = '0; id_uses_rs2 = 1'b0; ex_mem_rd = 1'b0;
        ex_rd = '0; branch_taken = 1'b0; halt_req = 1'b0; mem_busy = 1'b0;

        //     tag           rst rs1 rs2 u2 ld rd  br hr bsy  ctrl    h  mt
        step("reset",       1, 0,  0,  0, 0, 0,  0, 0, 0,  C_OFF,  0, 0);
        step("idle",        0, 0,  0,  0, 0, 0,  0, 0, 0,  C_RUN,  0, 0);
        step("lu_rs1",      0, 5,  0,  0, 1, 5,  0, 0, 0,  C_HOLD, 0, 0);
        step("lu_cleared",  0, 5,  0,  0, 0, 5,  0, 0, 0,  C_RUN,  0, 0);
        step("lu_rd0",      0, 0,  0,  0, 1, 0,  0, 0, 0,  C_RUN,  0, 0);
        step("lu_rs2_nouse",0, 3,  5,  0, 1, 5,  0, 0, 0,  C_RUN,  0, 0);
        step("lu_rs2_use",  0, 3,  5,  1, 1, 5,  0, 0, 0,  C_HOLD, 0, 0);
        step("br_and_lu",   0, 5,  0,  0, 1, 5,  1, 0, 0,  C_BR,   0, 0);
        step("busy1",       0, 0,  0,  0, 0, 0,  0, 0, 1,  C_OFF,  0, 0);
        step("busy2",       0, 0,  0,  0, 0, 0,  0, 0, 1,  C_OFF,  0, 0);
        step("busy3",       0, 0,  0,  0, 0, 0,  0, 0, 1,  C_OFF,  0, 0);
        step("busy_done",   0, 0,  0,  0, 0, 0,  0, 0, 0,  C_RUN,  0, 0);
        step("busy_again",  0, 0,  0,  0, 0, 0,  0, 0, 1,  C_OFF,  0, 0);
        step("wait_br",     0, 0,  0,  0, 0, 0,  1, 0, 0,  C_BR,   0, 0);
        step("wait_lu",     0, 7,  0,  0, 1, 7,  0, 0, 0,  C_HOLD, 0, 0);
        step("rw_busy1",    0, 0,  0,  0, 0, 0,  0, 0, 1,  C_OFF,  0, 0);
        step("rw_busy2",    0, 0,  0,  0, 0, 0,  0, 0, 1,  C_OFF,  0, 0);
        step("rw_reset",    1, 0,  0,  0, 0, 0,  0, 0, 1,  C_OFF,  0, 0);
        step("rw_after",    0, 0,  0,  0, 0, 0,  0, 0, 0,  C_RUN,  0, 0);
        step("to_busy1",    0, 0,  0,  0, 0, 0,  0, 0, 1,  C_OFF,  0, 0);
        step("to_busy2",    0, 0,  0,  0, 0, 0,  0, 0, 1,  C_OFF,  0, 0);
        step("to_busy3",    0, 0,  0,  0, 0, 0,  0, 0, 1,  C_OFF,  0, 0);
        step("to_busy4",    0, 0,  0,  0, 0, 0,  0, 0, 1,  C_OFF,  0, 0);
        step("to_halted",   0, 0,  0,  0, 0, 0,  0, 0, 1,  C_HOLD, 1, 1);
        step("to_ignore",   0, 0,  0,  0, 0, 0,  1, 0, 0,  C_HOLD, 1, 1);
        step("to_reset",    1, 0,  0,  0, 0, 0,  0, 0, 0,  C_OFF,  1, 1);
        step("to_after",    0, 0,  0,  0, 0, 0,  0, 0, 0,  C_RUN,  0, 0);
        step("halt_req",    0, 0,  0,  0, 0, 0,  0, 1, 0,  C_HOLD, 0, 0);
        step("halt_br",     0, 0,  0,  0, 0, 0,  1, 0, 0,  C_HOLD, 1, 0);
        step("halt_busy",   0, 0,  0,  0, 0, 0,  0, 0, 1,  C_HOLD, 1, 0);
        step("halt_idle",   0, 0,  0,  0, 0, 0,  0, 0, 0,  C_HOLD, 1, 0);
        step("end_reset",   1, 0,  0,  0, 0, 0,  0, 0, 0,  C_OFF,  1, 0);
        step("end_run",     0, 0,  0,  0, 0, 0,  0, 0, 0,  C_RUN,  0, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
